// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants, adaptation-field encodings and receiver FSM states.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int          TS_PKT_LEN   = 188;
    localparam logic [12:0] TS_PID_NULL  = 13'h1FFF;

    typedef enum logic [1:0] {
        AFC_RESERVED = 2'b00,
        AFC_PAYLOAD  = 2'b01,
        AFC_ADAPT    = 2'b10,
        AFC_BOTH     = 2'b11
    } afc_t;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

endpackage

// File: rtl/ts_packet_receiver_if.sv
// TS byte stream in, parsed header fields and QoS counters out; the source side is master.
interface ts_packet_receiver_if;
    import ts_pkg::*;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [12:0] pid_sel;

    logic        locked;
    logic        pkt_start;
    logic        hdr_valid;
    logic [12:0] pkt_pid;
    logic [3:0]  pkt_cc;
    logic        pkt_tei;
    logic        pkt_pusi;
    afc_t        pkt_afc;
    logic        cc_err;
    logic [31:0] pkt_count;
    logic [31:0] cc_err_count;
    logic [15:0] sync_loss_count;

    modport master (
        output byte_valid, byte_data, pid_sel,
        input  locked, pkt_start, hdr_valid, pkt_pid, pkt_cc, pkt_tei, pkt_pusi,
               pkt_afc, cc_err, pkt_count, cc_err_count, sync_loss_count
    );

    modport slave (
        input  byte_valid, byte_data, pid_sel,
        output locked, pkt_start, hdr_valid, pkt_pid, pkt_cc, pkt_tei, pkt_pusi,
               pkt_afc, cc_err, pkt_count, cc_err_count, sync_loss_count
    );

endinterface

// File: rtl/ts_cc_checker.sv
// Continuity-counter check for one selected PID; cc_err registered 1 cycle after chk.
// No backpressure: one check per strobe.
module ts_cc_checker
    import ts_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        chk,
    input  logic [12:0] pid,
    input  logic [12:0] pid_sel,
    input  logic [3:0]  cc,
    input  afc_t        afc,
    output logic        cc_err
);

    logic [12:0] pid_sel_q;
    logic        ref_vld;
    logic [3:0]  ref_cc;

    logic        sel_hit;
    logic        payload;
    logic        dup;
    logic        mismatch;
    logic [3:0]  exp_cc;

    always_comb begin
        sel_hit  = chk && (pid == pid_sel) && (pid_sel != TS_PID_NULL);
        payload  = (afc == AFC_PAYLOAD) || (afc == AFC_BOTH);
        exp_cc   = payload ? ref_cc + 4'd1 : ref_cc;
        dup      = payload && (cc == ref_cc);
        mismatch = ref_vld && (cc != exp_cc) && !dup;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pid_sel_q <= '0;
            ref_vld   <= 1'b0;
            ref_cc    <= '0;
            cc_err    <= 1'b0;
        end else begin
            pid_sel_q <= pid_sel;
            cc_err    <= sel_hit && mismatch;
            if (sel_hit) begin
                ref_cc  <= cc;
                ref_vld <= 1'b1;
            end
            // a new selection invalidates whatever reference was being tracked
            if (pid_sel != pid_sel_q) begin
                ref_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ts_packet_receiver.sv
// TS sync hunt/lock, 4-byte header parse and saturating QoS counters; outputs registered 1 cycle
// after the relevant byte is accepted. No backpressure: one byte per cycle when byte_valid.
module ts_packet_receiver
    import ts_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PKT_LEN      = TS_PKT_LEN,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic                clk,
    input  logic                reset,
    ts_packet_receiver_if.slave ts
);

    localparam int IW = $clog2(PKT_LEN);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(PKT_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] SYNC     = DATA_WIDTH'(TS_SYNC_BYTE);

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [GW-1:0] good, good_nxt;
    logic [MW-1:0] miss, miss_nxt;
    logic          pkt_ok, pkt_ok_nxt;
    logic          start_nxt;
    logic          loss_nxt;

    logic          acc;
    logic          is_sync;
    logic          parse;
    logic          hdr_chk;
    logic          tei_s;
    logic          pusi_s;
    logic [4:0]    pid_hi;
    logic [7:0]    pid_lo;
    logic          cc_err;

    assign acc       = ts.byte_valid;
    assign is_sync   = (ts.byte_data == SYNC);
    assign parse     = pkt_ok && (state == LOCKED);
    assign hdr_chk   = acc && parse && (idx == IW'(3));
    assign ts.locked = (state == LOCKED);
    assign ts.cc_err = cc_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HUNT;
            idx    <= '0;
            good   <= '0;
            miss   <= '0;
            pkt_ok <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            good   <= good_nxt;
            miss   <= miss_nxt;
            pkt_ok <= pkt_ok_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        good_nxt   = good;
        miss_nxt   = miss;
        pkt_ok_nxt = pkt_ok;
        start_nxt  = 1'b0;
        loss_nxt   = 1'b0;
        if (acc) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            unique case (state)
                HUNT: begin
                    idx_nxt = '0;
                    if (is_sync) begin
                        idx_nxt   = IW'(1);
                        good_nxt  = GW'(1);
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (idx == '0) begin
                        if (!is_sync) begin
                            state_nxt = HUNT;
                            idx_nxt   = '0;
                        end else if (good == GW'(LOCK_COUNT - 1)) begin
                            // the packet completing lock is itself parsed
                            state_nxt  = LOCKED;
                            good_nxt   = GW'(LOCK_COUNT);
                            miss_nxt   = '0;
                            pkt_ok_nxt = 1'b1;
                            start_nxt  = 1'b1;
                        end else begin
                            good_nxt = good + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (idx == '0) begin
                        if (is_sync) begin
                            miss_nxt   = '0;
                            pkt_ok_nxt = 1'b1;
                            start_nxt  = 1'b1;
                        end else begin
                            pkt_ok_nxt = 1'b0;
                            miss_nxt   = miss + 1'b1;
                            if (miss == MW'(UNLOCK_COUNT - 1)) begin
                                state_nxt = HUNT;
                                idx_nxt   = '0;
                                loss_nxt  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts.pkt_start       <= 1'b0;
            ts.hdr_valid       <= 1'b0;
            ts.pkt_pid         <= '0;
            ts.pkt_cc          <= '0;
            ts.pkt_tei         <= 1'b0;
            ts.pkt_pusi        <= 1'b0;
            ts.pkt_afc         <= AFC_RESERVED;
            ts.pkt_count       <= '0;
            ts.cc_err_count    <= '0;
            ts.sync_loss_count <= '0;
            tei_s              <= 1'b0;
            pusi_s             <= 1'b0;
            pid_hi             <= '0;
            pid_lo             <= '0;
        end else begin
            ts.pkt_start <= start_nxt;
            ts.hdr_valid <= 1'b0;
            if (loss_nxt && (ts.sync_loss_count != '1)) begin
                ts.sync_loss_count <= ts.sync_loss_count + 16'd1;
            end
            if (cc_err && (ts.cc_err_count != '1)) begin
                ts.cc_err_count <= ts.cc_err_count + 32'd1;
            end
            if (acc && parse) begin
                if (idx == IW'(1)) begin
                    tei_s  <= ts.byte_data[7];
                    pusi_s <= ts.byte_data[6];
                    pid_hi <= ts.byte_data[4:0];
                end else if (idx == IW'(2)) begin
                    pid_lo <= ts.byte_data[7:0];
                end else if (idx == IW'(3)) begin
                    ts.pkt_pid   <= {pid_hi, pid_lo};
                    ts.pkt_tei   <= tei_s;
                    ts.pkt_pusi  <= pusi_s;
                    ts.pkt_cc    <= ts.byte_data[3:0];
                    ts.pkt_afc   <= afc_t'(ts.byte_data[5:4]);
                    ts.hdr_valid <= 1'b1;
                    if (ts.pkt_count != '1) begin
                        ts.pkt_count <= ts.pkt_count + 32'd1;
                    end
                end
            end
        end
    end

    ts_cc_checker u_cc_checker (
        .clk     (clk),
        .reset   (reset),
        .chk     (hdr_chk),
        .pid     ({pid_hi, pid_lo}),
        .pid_sel (ts.pid_sel),
        .cc      (ts.byte_data[3:0]),
        .afc     (afc_t'(ts.byte_data[5:4])),
        .cc_err  (cc_err)
    );

endmodule

// File: tb/tb_ts_packet_receiver.sv
// Randomized stream bench: a packet-level reference model fills a scoreboard that a monitor drains.
module tb_ts_packet_receiver;
    import ts_pkg::*;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 3;
    localparam int PLEN   = 188;

    logic clk;
    logic reset;
    ts_packet_receiver_if ts ();

    ts_packet_receiver #(
        .DATA_WIDTH   (8),
        .PKT_LEN      (PLEN),
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ts    (ts)
    );

    typedef struct {
        logic [12:0] pid;
        logic [3:0]  cc;
        logic        tei;
        logic        pusi;
        logic [1:0]  afc;
        logic        err;
        int          cnt;
        int          errs;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   gaps     = 0;
    logic [12:0] sel;

    // reference model, one step per packet
    bit aligned;
    int run, miss_run, m_loss, m_pkts, m_errs, m_last;
    bit m_held;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        aligned  = 0;
        run      = 0;
        miss_run = 0;
        m_loss   = 0;
        m_pkts   = 0;
        m_errs   = 0;
        m_held   = 0;
        m_last   = 0;
        exp_q.delete();
    endtask

    task automatic model_pkt(input bit sync_ok, input logic [12:0] pid, input logic [3:0] cc,
                             input logic [1:0] afc, input logic tei, input logic pusi,
                             output bit valid);
        exp_t e;
        bit   err;
        valid = 0;
        if (!aligned) begin
            if (!sync_ok) run = 0;
            else run = run + 1;
            if (run >= LOCK) begin
                aligned  = 1;
                miss_run = 0;
                valid    = 1;
            end
        end else if (sync_ok) begin
            miss_run = 0;
            valid    = 1;
        end else begin
            miss_run++;
            if (miss_run >= UNLOCK) begin
                aligned = 0;
                run     = 0;
                m_loss++;
            end
        end
        if (valid) begin
            err = 0;
            if (pid == sel && pid != 13'h1FFF) begin
                if (m_held) begin
                    if (afc[0]) err = !((cc == m_last) || (cc == (m_last + 1) % 16));
                    else        err = (cc != m_last);
                end
                m_held = 1;
                m_last = int'(cc);
            end
            m_pkts++;
            if (err) m_errs++;
            e.pid = pid; e.cc = cc; e.tei = tei; e.pusi = pusi; e.afc = afc;
            e.err = err; e.cnt = m_pkts; e.errs = m_errs;
            exp_q.push_back(e);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        while (gaps && ($urandom_range(0, 99) < 30)) begin
            ts.byte_valid = 1'b0;
            @(negedge clk);
        end
        ts.byte_valid = 1'b1;
        ts.byte_data  = b;
        @(negedge clk);
        ts.byte_valid = 1'b0;
    endtask

    task automatic send_pkt(input bit sync_ok, input logic [12:0] pid, input logic [3:0] cc,
                            input logic [1:0] afc, input int nbytes);
        logic       tei, pusi;
        logic [7:0] b;
        bit         valid;
        tei  = 1'($urandom_range(0, 1));
        pusi = 1'($urandom_range(0, 1));
        model_pkt(sync_ok, pid, cc, afc, tei, pusi, valid);
        put_byte(sync_ok ? 8'h47 : 8'h00);
        chk("locked_after_sync", 64'(ts.locked), 64'(aligned));
        chk("pkt_start", 64'(ts.pkt_start), 64'(valid));
        chk("sync_loss_count", 64'(ts.sync_loss_count), 64'(m_loss));
        put_byte({tei, pusi, 1'b0, pid[12:8]});
        put_byte(pid[7:0]);
        put_byte({2'b00, afc, cc});
        for (int i = 4; i < nbytes; i++) begin
            do b = 8'($urandom); while (b == 8'h47);
            put_byte(b);
        end
    endtask

    task automatic set_sel(input logic [12:0] v);
        if (v != sel) m_held = 0;
        sel        = v;
        ts.pid_sel = v;
    endtask

    task automatic do_reset();
        ts.byte_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 64'({ts.locked, ts.pkt_start, ts.hdr_valid, ts.cc_err}), 64'd0);
        chk({tag, "_hdr"}, 64'({ts.pkt_pid, ts.pkt_cc, ts.pkt_tei, ts.pkt_pusi, ts.pkt_afc}), 64'd0);
        chk({tag, "_pkt_count"}, 64'(ts.pkt_count), 64'd0);
        chk({tag, "_cc_err_count"}, 64'(ts.cc_err_count), 64'd0);
        chk({tag, "_sync_loss_count"}, 64'(ts.sync_loss_count), 64'd0);
    endtask

    task automatic idle(input int n);
        ts.byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        int   pend;
        pend = -1;
        forever begin
            @(negedge clk);
            if (pend >= 0) begin
                chk("cc_err_count_lag", 64'(ts.cc_err_count), 64'(pend));
                pend = -1;
            end
            if (ts.cc_err) chk("cc_err_with_hdr", 64'(ts.hdr_valid), 64'd1);
            if (ts.hdr_valid) begin
                chk("hdr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("hdr_pid", 64'(ts.pkt_pid), 64'(e.pid));
                    chk("hdr_cc", 64'(ts.pkt_cc), 64'(e.cc));
                    chk("hdr_tei_pusi", 64'({ts.pkt_tei, ts.pkt_pusi}), 64'({e.tei, e.pusi}));
                    chk("hdr_afc", 64'(ts.pkt_afc), 64'(e.afc));
                    chk("hdr_cc_err", 64'(ts.cc_err), 64'(e.err));
                    chk("hdr_pkt_count", 64'(ts.pkt_count), 64'(e.cnt));
                    pend = e.errs;
                end
            end
        end
    end

    initial begin : stimulus
        logic [12:0] pids [3];
        pids[0] = 13'h100; pids[1] = 13'h0A5; pids[2] = 13'h1FFF;
        reset         = 1'b1;
        ts.byte_valid = 1'b0;
        ts.byte_data  = 8'h00;
        sel           = 13'h100;
        ts.pid_sel    = 13'h100;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) send_pkt(1, 13'h100, 4'(i), AFC_PAYLOAD, PLEN);
        idle(4);
        chk("s1_pkt_count", 64'(ts.pkt_count), 64'd3);
        chk("s1_cc_err_count", 64'(ts.cc_err_count), 64'd0);

        send_pkt(1, 13'h100, 4'd5, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h100, 4'd6, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h100, 4'd8, AFC_PAYLOAD, PLEN);
        idle(4);
        chk("s2_cc_err_count", 64'(ts.cc_err_count), 64'd1);

        send_pkt(1, 13'h100, 4'd9, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h100, 4'd9, AFC_ADAPT, PLEN);
        send_pkt(1, 13'h100, 4'd9, AFC_ADAPT, PLEN);
        set_sel(13'h0A5);
        send_pkt(1, 13'h0A5, 4'd4, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h0A5, 4'd4, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h100, 4'd0, AFC_PAYLOAD, PLEN);
        send_pkt(1, 13'h0A5, 4'd5, AFC_BOTH, PLEN);
        idle(4);
        chk("s3_cc_err_count", 64'(ts.cc_err_count), 64'd1);

        for (int i = 0; i < 3; i++) send_pkt(0, 13'h0A5, 4'd6, AFC_PAYLOAD, PLEN);
        for (int i = 0; i < 5; i++) send_pkt(1, 13'h0A5, 4'(6 + i), AFC_PAYLOAD, PLEN);
        idle(4);
        chk("s4_sync_loss_count", 64'(ts.sync_loss_count), 64'd1);
        chk("s4_relocked", 64'(ts.locked), 64'd1);
        chk("s4_pkt_count", 64'(ts.pkt_count), 64'(m_pkts));

        for (int i = 0; i < 10; i++) begin
            send_pkt($urandom_range(0, 9) != 0, pids[$urandom_range(0, 2)],
                     4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), PLEN);
        end
        set_sel(13'h1FFF);
        for (int i = 0; i < 3; i++) send_pkt(1, 13'h1FFF, 4'($urandom_range(0, 15)), AFC_PAYLOAD, PLEN);
        idle(4);
        chk("rand_cc_err_count", 64'(ts.cc_err_count), 64'(m_errs));
        chk("rand_pkt_count", 64'(ts.pkt_count), 64'(m_pkts));

        set_sel(13'h100);
        do_reset();
        gaps = 1;
        for (int i = 0; i < 5; i++) send_pkt(1, 13'h100, 4'(i), AFC_PAYLOAD, PLEN);
        idle(4);
        chk("s5_pkt_count", 64'(ts.pkt_count), 64'd3);
        chk("s5_cc_err_count", 64'(ts.cc_err_count), 64'd0);
        chk("s5_sync_loss_count", 64'(ts.sync_loss_count), 64'd0);

        send_pkt(1, 13'h100, 4'd5, AFC_PAYLOAD, 100);
        ts.byte_valid = 1'b1;
        ts.byte_data  = 8'h12;
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        ts.byte_valid = 1'b0;
        model_reset();
        gaps = 0;
        for (int i = 0; i < 3; i++) send_pkt(1, 13'h100, 4'(i), AFC_PAYLOAD, PLEN);
        idle(4);
        chk("s6_relocked", 64'(ts.locked), 64'd1);
        chk("s6_pkt_count", 64'(ts.pkt_count), 64'd1);

        idle(10);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ts_packet_receiver.md
# ts_packet_receiver

Byte-stream sink for MPEG-2 TS inputs of the QoS-control path, consuming the 8-bit stream that the file-driven stimulus produces on `wclk`. It hunts for and locks onto 188-byte packet alignment using sync byte 0x47, and parses the 4-byte header. It also checks continuity-counter (CC) sequencing on one selected PID and keeps saturating QoS counters for packets, CC errors and sync losses. One instance sits on each of the four TS channels.

## Interface
- `DATA_WIDTH`, 8: byte width; only 8 is supported.
- `PKT_LEN`, 188: packet length in bytes.
- `LOCK_COUNT`, 3: consecutive good syncs, counting the first, needed to lock; minimum 2.
- `UNLOCK_COUNT`, 3: consecutive bad syncs that drop lock; minimum 1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `byte_valid` in 1: qualifies `byte_data`. Tie to 1 for continuous streams.
- `byte_data` in 8: TS byte.
- `pid_sel` in 13: PID whose CC is checked.
- `locked` out 1: packet alignment acquired.
- `pkt_start` out 1: 1-cycle pulse, a packet's sync byte was accepted while locked.
- `hdr_valid` out 1: 1-cycle pulse, header fields are valid and held until the next pulse.
- `pkt_pid` out 13, `pkt_cc` out 4, `pkt_tei` out 1, `pkt_pusi` out 1, `pkt_afc` out 2: header fields.
- `cc_err` out 1: 1-cycle pulse, coincident with `hdr_valid`.
- `pkt_count` out 32, `cc_err_count` out 32, `sync_loss_count` out 16: saturating counters.

## Operation
- Only bytes with `byte_valid`=1 are "accepted". All counting and parsing ignores other cycles.
- `byte_idx` is a 0..PKT_LEN-1 position counter. It wraps PKT_LEN-1 -> 0. Index 0 is the expected sync position.
- The state machine has three states: HUNT, VERIFY and LOCKED.
- HUNT:
  - An accepted byte of 0x47 sets `byte_idx`=1 and `good`=1, then moves to VERIFY.
  - Any other byte is discarded.
- VERIFY:
  - At index 0, a byte of 0x47 increments `good`. When `good` reaches LOCK_COUNT, move to LOCKED.
  - At index 0, any other byte returns to HUNT. That byte is not rescanned.
  - No headers are parsed in VERIFY.
- LOCKED:
  - At index 0, a byte of 0x47 clears `miss`. The packet is valid and `pkt_start` pulses.
  - At index 0, any other byte increments `miss`. The packet is invalid: no `pkt_start`, no header.
  - When `miss` reaches UNLOCK_COUNT, go to HUNT and increment `sync_loss_count`.
  - The packet that completes lock is treated as valid and is parsed.
- Header extraction, valid packets only:
  - Index 1: `tei`=b7, `pusi`=b6, `pid[12:8]`=b4:0.
  - Index 2: `pid[7:0]`.
  - Index 3: `afc`=b5:4 and `cc`=b3:0.
  - `hdr_valid` pulses, and `pkt_count` increments.
- CC check, performed only when `pkt_pid`==`pid_sel` and `pid_sel`!=0x1FFF:
  - If no reference is held, store `cc` and raise no error.
  - A payload is present when `afc`[0]=1. The expected value is last+1 mod 16 if a payload is present, otherwise last.
  - A payload packet whose CC equals last is a permitted duplicate and is not an error.
  - In any other mismatch, pulse `cc_err` and increment `cc_err_count`.
  - The reference is updated to `cc` on every checked packet.
- Any change of `pid_sel` compared with its registered copy clears the reference-held flag on the next cycle.
- All counters saturate at all-ones.
- Reset values:
  - State is HUNT, all index and counter registers are 0, and the reference flag is cleared.
  - Every output is 0, including header fields and counters.

## Timing
- `locked` rises 1 cycle after the LOCK_COUNT-th good sync is accepted.
- `locked` falls 1 cycle after the UNLOCK_COUNT-th bad sync is accepted. `sync_loss_count` updates in that same cycle.
- `pkt_start` occurs 1 cycle after the sync byte is accepted.
- `hdr_valid`, `cc_err`, the header fields and `pkt_count` are registered 1 cycle after the index-3 byte is accepted.
- `cc_err_count` updates 1 cycle after `cc_err`.
- Throughput is 1 byte per cycle, with no backpressure.
- Gaps in `byte_valid` stretch the timing but never alter any result.
- Reset asserted mid-packet takes effect on the next edge and overrides `byte_valid`. After release, the block restarts in HUNT.

## Structure
- Package `ts_pkg` holds:
  - constants `TS_SYNC_BYTE`=8'h47, `TS_PKT_LEN`=188, `TS_PID_NULL`=13'h1FFF;
  - AFC encodings (00 reserved, 01 payload only, 10 adaptation only, 11 both);
  - the state enum {HUNT, VERIFY, LOCKED}.
- Sub-module `ts_cc_checker`: the reference register and valid flag, the `pid_sel` change detector, the expected-CC and duplicate logic, and `cc_err` generation.

## Test plan
- Five clean packets on PID 0x100 with CC 0..4 and `pid_sel`=0x100 -> `locked` rises after the 3rd sync; `pkt_count`=3, `cc_err_count`=0.
- Locked, CC sequence 5,6,8 on the selected PID -> one `cc_err` pulse on the CC=8 header; `cc_err_count`=1.
- Locked, CC 9 with AFC=10 followed by CC 9 with AFC=10; separately, CC 4,4 with AFC=01 -> no `cc_err` in either case.
- Locked, then the sync byte corrupted to 0x00 on 3 consecutive packets followed by good packets:
  - `locked` drops at the 3rd bad boundary and `sync_loss_count`=1;
  - the block re-locks after 3 good syncs;
  - headers of the bad packets are not counted.
- Scenario 1 with `byte_valid` randomly low 30% of cycles -> identical counters and header values.
- `reset` pulsed at byte 100 of a locked packet -> the next cycle all outputs are 0 and the state is HUNT; the block re-locks normally afterwards.
